// File: rtl/regfile_pkg.sv
// ------------------------------------------------------------------
// regfile_pkg : shared types for the register-file write controller
// Revision    : 1.0
// ------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int unsigned c_addr_width = 5;
  localparam int unsigned c_data_width = 32;

  typedef logic [c_addr_width-1:0] reg_addr_t;
  typedef logic [c_data_width-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_ctrl_fifo.sv
// ------------------------------------------------------------------
// wb_fifo  : synchronous FIFO of writeback requests
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
// ------------------------------------------------------------------
// regfile_wb_ctrl : register-file write port owner merging ALU and LSU writebacks
// Revision        : 1.0
// ------------------------------------------------------------------
`default_nettype none

module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = c_addr_width,
  parameter int unsigned DATA_WIDTH = c_data_width,
  parameter int unsigned Q_DEPTH    = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_addr,
  input  logic                     alu_we,
  input  logic [ADDR_WIDTH-1:0]    alu_a,
  input  logic [DATA_WIDTH-1:0]    alu_wd,
  output logic                     alu_stall,
  input  logic                     lsu_valid,
  input  logic [ADDR_WIDTH-1:0]    lsu_a,
  input  logic [DATA_WIDTH-1:0]    lsu_wd,
  output logic                     lsu_ready,
  output logic [ADDR_WIDTH-1:0]    a3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     we3,
  output logic [2**ADDR_WIDTH-1:0] pending
);

  localparam int unsigned NREG = 2**ADDR_WIDTH;
  localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t            push_req, head;
  logic            push, pop, full, empty;
  logic            alu_req, alu_win;

  logic [ADDR_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
  logic                  we3_q, we3_d;
  logic                  alu_stall_q, alu_stall_d;
  logic [ST_W-1:0]       starve_q, starve_d;
  logic [NREG-1:0]       pending_q, pending_d;

  wb_fifo #(
    .DEPTH (Q_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_req),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign lsu_ready = !full;

  always_comb begin
    push_req.addr = lsu_a;
    push_req.data = lsu_wd;
    // register-0 beats complete the handshake but are dropped here
    push    = lsu_valid && !full && (lsu_a != '0);
    alu_req = alu_we && (alu_a != '0);
    pop     = !empty && (alu_stall_q || !alu_req);
    alu_win = alu_req && !pop;

    we3_d = pop || alu_win;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (pop) begin
      a3_d  = head.addr;
      wd3_d = head.data;
    end else if (alu_win) begin
      a3_d  = alu_a;
      wd3_d = alu_wd;
    end

    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (!empty && alu_win) begin
      starve_d = starve_q + ST_W'(1);
    end
    alu_stall_d = (starve_d == ST_W'(STARVE_MAX));

    // clear first so a same-cycle reservation of the same register wins
    pending_d = pending_q;
    if (pop) begin
      pending_d[head.addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a3_q        <= '0;
      wd3_q       <= '0;
      we3_q       <= 1'b0;
      alu_stall_q <= 1'b0;
      starve_q    <= '0;
      pending_q   <= '0;
    end else begin
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      we3_q       <= we3_d;
      alu_stall_q <= alu_stall_d;
      starve_q    <= starve_d;
      pending_q   <= pending_d;
    end
  end

  assign a3        = a3_q;
  assign wd3       = wd3_q;
  assign we3       = we3_q;
  assign alu_stall = alu_stall_q;
  assign pending   = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// ------------------------------------------------------------------
// tb_regfile_wb_ctrl : directed self-checking bench for regfile_wb_ctrl
// Revision           : 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        alu_we;
  logic [4:0]  alu_a;
  logic [31:0] alu_wd;
  logic        alu_stall;
  logic        lsu_valid;
  logic [4:0]  lsu_a;
  logic [31:0] lsu_wd;
  logic        lsu_ready;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] pending;

  int tests = 0;
  int fails = 0;

  regfile_wb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .alu_we      (alu_we),
    .alu_a       (alu_a),
    .alu_wd      (alu_wd),
    .alu_stall   (alu_stall),
    .lsu_valid   (lsu_valid),
    .lsu_a       (lsu_a),
    .lsu_wd      (lsu_wd),
    .lsu_ready   (lsu_ready),
    .a3          (a3),
    .wd3         (wd3),
    .we3         (we3),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    issue_valid = 1'b0; issue_addr = '0;
    alu_we = 1'b0; alu_a = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_a = '0; lsu_wd = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0 || alu_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: we3=%b a3=%0d wd3=%h stall=%b, want 0 0 0 0", we3, a3, wd3, alu_stall);
    end
    tests++;
    if (pending !== 32'd0 || lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: pending=%h ready=%b, want 0 1", pending, lsu_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // asynchronous assertion mid-cycle right after a write was registered
    alu_we = 1'b1; alu_a = 5'd3; alu_wd = 32'h0000_0033;
    tick();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (we3 !== 1'b0 || pending !== 32'd0 || lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: we3=%b pending=%h ready=%b, want 0 0 1", we3, pending, lsu_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_write;
    alu_we = 1'b1; alu_a = 5'd5; alu_wd = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    tests++;
    if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL alu_write: we3=%b a3=%0d wd3=%h, want 1 5 deadbeef", we3, a3, wd3);
    end
    tick();
    tests++;
    if (we3 !== 1'b0) begin
      fails++;
      $display("FAIL alu_one_cycle: we3=%b, want 0", we3);
    end
  endtask

  task automatic test_reg0;
    alu_we = 1'b1; alu_a = 5'd0; alu_wd = 32'h55;
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    idle_inputs();
    tests++;
    if (we3 !== 1'b0 || pending !== 32'd0) begin
      fails++;
      $display("FAIL reg0_alu_issue: we3=%b pending=%h, want 0 0", we3, pending);
    end
    lsu_valid = 1'b1; lsu_a = 5'd0; lsu_wd = 32'h77;
    #1;
    tests++;
    if (lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL reg0_lsu_ready: ready=%b, want 1", lsu_ready);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (we3 !== 1'b0) begin
        fails++;
        $display("FAIL reg0_lsu_nowrite: cycle %0d we3=%b a3=%0d, want we3 0", i, we3, a3);
      end
    end
  endtask

  task automatic test_load_path;
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    idle_inputs();
    tests++;
    if (pending !== 32'h0000_0080) begin
      fails++;
      $display("FAIL load_reserve: pending=%h, want 00000080", pending);
    end
    lsu_valid = 1'b1; lsu_a = 5'd7; lsu_wd = 32'h1234;
    tick();
    idle_inputs();
    tests++;
    if (we3 !== 1'b0 || pending !== 32'h0000_0080) begin
      fails++;
      $display("FAIL load_enqueue: we3=%b pending=%h, want 0 00000080", we3, pending);
    end
    tick();
    tests++;
    if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h1234 || pending !== 32'd0) begin
      fails++;
      $display("FAIL load_write: we3=%b a3=%0d wd3=%h pending=%h, want 1 7 1234 0", we3, a3, wd3, pending);
    end
    tick();
    tests++;
    if (we3 !== 1'b0) begin
      fails++;
      $display("FAIL load_one_cycle: we3=%b, want 0", we3);
    end
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 4; i++) begin
      alu_we = 1'b1; alu_a = 5'(10 + i); alu_wd = 32'hA0 + 32'(i);
      lsu_valid = 1'b1; lsu_a = 5'(1 + i); lsu_wd = 32'h100 + 32'(1 + i);
      #1;
      tests++;
      if (lsu_ready !== 1'b1) begin
        fails++;
        $display("FAIL full_ready_beat%0d: ready=%b, want 1", i + 1, lsu_ready);
      end
      tick();
      tests++;
      if (we3 !== 1'b1 || a3 !== 5'(10 + i) || alu_stall !== (i == 3)) begin
        fails++;
        $display("FAIL full_alu%0d: we3=%b a3=%0d stall=%b, want 1 %0d %b", i, we3, a3, alu_stall, 10 + i, i == 3);
      end
    end
    tests++;
    if (lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_not_ready: ready=%b, want 0", lsu_ready);
    end
    alu_we = 1'b1; alu_a = 5'd14; alu_wd = 32'hEE;
    lsu_valid = 1'b1; lsu_a = 5'd5; lsu_wd = 32'h105;
    tick();
    idle_inputs();
    tests++;
    if (we3 !== 1'b1 || a3 !== 5'd1 || wd3 !== 32'h101 || alu_stall !== 1'b0 || lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_forced_pop: we3=%b a3=%0d wd3=%h stall=%b ready=%b, want 1 1 101 0 1", we3, a3, wd3, alu_stall, lsu_ready);
    end
    for (int n = 2; n <= 4; n++) begin
      tick();
      tests++;
      if (we3 !== 1'b1 || a3 !== 5'(n) || wd3 !== 32'h100 + 32'(n)) begin
        fails++;
        $display("FAIL full_drain%0d: we3=%b a3=%0d wd3=%h, want 1 %0d %h", n, we3, a3, wd3, n, 32'h100 + 32'(n));
      end
    end
    tick();
    tests++;
    if (we3 !== 1'b0 || alu_stall !== 1'b0) begin
      fails++;
      $display("FAIL full_drained: we3=%b stall=%b, want 0 0", we3, alu_stall);
    end
  endtask

  task automatic test_set_clear_race;
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle_inputs();
    lsu_valid = 1'b1; lsu_a = 5'd9; lsu_wd = 32'h99;
    tick();
    idle_inputs();
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle_inputs();
    tests++;
    if (we3 !== 1'b1 || a3 !== 5'd9 || pending !== 32'h0000_0200) begin
      fails++;
      $display("FAIL race_set_wins: we3=%b a3=%0d pending=%h, want 1 9 00000200", we3, a3, pending);
    end
    tick();
  endtask

  task automatic test_reset_mid_op;
    issue_valid = 1'b1; issue_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      alu_we = 1'b1; alu_a = 5'(20 + i); alu_wd = 32'(i);
      lsu_valid = 1'b1; lsu_a = 5'(1 + i); lsu_wd = 32'h200 + 32'(i);
      tick();
      issue_valid = 1'b0;
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (we3 !== 1'b0 || pending !== 32'd0 || lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL midop_reset: we3=%b pending=%h ready=%b, want 0 0 1", we3, pending, lsu_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (we3 !== 1'b0 || pending !== 32'd0 || lsu_ready !== 1'b1) begin
        fails++;
        $display("FAIL midop_quiet%0d: we3=%b a3=%0d pending=%h ready=%b, want 0 - 0 1", i, we3, a3, pending, lsu_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_reg0();
    test_load_path();
    test_fifo_full();
    test_set_clear_race();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
